// File: rtl/d_mem_req_hold_if.sv
// Q103H data-memory request bus between core, hold stage and memory decode.
// Carries core request, re-driven memory request, stall/replay flags and stats.
interface d_mem_req_hold_if #(
    parameter int CNT_W = 16
);
    logic             DMemReady;
    logic             CoreReqValidQ103H;
    logic [31:0]      CoreReqAddrQ103H;
    logic [31:0]      CoreReqDataQ103H;
    logic [3:0]       CoreReqByteEnQ103H;
    logic             CoreReqWrEnQ103H;
    logic             CoreReqRdEnQ103H;
    logic             MemReqValidQ103H;
    logic [31:0]      MemReqAddrQ103H;
    logic [31:0]      MemReqDataQ103H;
    logic [3:0]       MemReqByteEnQ103H;
    logic             MemReqWrEnQ103H;
    logic             MemReqRdEnQ103H;
    logic             CoreStall;
    logic             ReplayQ103H;
    logic [CNT_W-1:0] StallCnt;
    logic [CNT_W-1:0] ReplayCnt;
    logic             TimeoutErr;

    modport slave (
        input  DMemReady, CoreReqValidQ103H, CoreReqAddrQ103H, CoreReqDataQ103H,
               CoreReqByteEnQ103H, CoreReqWrEnQ103H, CoreReqRdEnQ103H,
        output MemReqValidQ103H, MemReqAddrQ103H, MemReqDataQ103H, MemReqByteEnQ103H,
               MemReqWrEnQ103H, MemReqRdEnQ103H, CoreStall, ReplayQ103H,
               StallCnt, ReplayCnt, TimeoutErr
    );

    modport master (
        output DMemReady, CoreReqValidQ103H, CoreReqAddrQ103H, CoreReqDataQ103H,
               CoreReqByteEnQ103H, CoreReqWrEnQ103H, CoreReqRdEnQ103H,
        input  MemReqValidQ103H, MemReqAddrQ103H, MemReqDataQ103H, MemReqByteEnQ103H,
               MemReqWrEnQ103H, MemReqRdEnQ103H, CoreStall, ReplayQ103H,
               StallCnt, ReplayCnt, TimeoutErr
    );
endinterface

// File: rtl/d_mem_req_hold.sv
// Q103H data-memory request hold/replay: captures a request the memory refuses,
// stalls the core and re-drives the held copy until accepted; watchdog + counters.
module d_mem_req_hold #(
    parameter int TIMEOUT_CYCLES = 256,
    parameter int CNT_W          = 16
) (
    input  logic             i_clk,
    input  logic             i_rst_n,
    d_mem_req_hold_if.slave  bus
);
    typedef enum logic {IDLE, HOLD} state_t;

    typedef struct packed {
        logic [31:0] addr;
        logic [31:0] data;
        logic [3:0]  be;
        logic        wr;
        logic        rd;
    } req_t;

    localparam logic [CNT_W-1:0] CNT_MAX     = '1;
    localparam logic [CNT_W-1:0] CNT_ONE     = CNT_W'(1);
    localparam logic [CNT_W-1:0] TIMEOUT_VAL = CNT_W'(TIMEOUT_CYCLES);

    state_t           r_state, w_state_nxt;
    req_t             r_hold, w_core_req, w_mem_req;
    logic [CNT_W-1:0] r_stall_cnt, w_stall_cnt_nxt, r_replay_cnt;
    logic             r_timeout;
    logic             w_capture, w_mem_valid, w_stall, w_replay;

    assign w_core_req = '{addr: bus.CoreReqAddrQ103H, data: bus.CoreReqDataQ103H,
                          be: bus.CoreReqByteEnQ103H, wr: bus.CoreReqWrEnQ103H,
                          rd: bus.CoreReqRdEnQ103H};

    always_comb begin
        w_state_nxt     = r_state;
        w_stall_cnt_nxt = '0;
        w_capture       = 1'b0;
        w_mem_valid     = bus.CoreReqValidQ103H;
        w_mem_req       = w_core_req;
        w_stall         = 1'b0;
        w_replay        = 1'b0;
        case (r_state)
            IDLE: begin
                if (bus.CoreReqValidQ103H && !bus.DMemReady) begin
                    w_stall         = 1'b1;
                    w_capture       = 1'b1;
                    w_stall_cnt_nxt = CNT_ONE;
                    w_state_nxt     = HOLD;
                end
            end
            HOLD: begin
                // Core inputs are ignored here; the held copy owns the bus
                w_mem_valid = 1'b1;
                w_mem_req   = r_hold;
                w_replay    = 1'b1;
                if (!bus.DMemReady) begin
                    w_stall         = 1'b1;
                    w_stall_cnt_nxt = (r_stall_cnt == CNT_MAX) ? r_stall_cnt
                                                               : r_stall_cnt + CNT_ONE;
                end else begin
                    w_state_nxt = IDLE;
                end
            end
            default: w_state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            r_state      <= IDLE;
            r_hold       <= '0;
            r_stall_cnt  <= '0;
            r_replay_cnt <= '0;
            r_timeout    <= 1'b0;
        end else begin
            r_state     <= w_state_nxt;
            r_stall_cnt <= w_stall_cnt_nxt;
            if (w_capture) begin
                r_hold <= w_core_req;
                if (r_replay_cnt != CNT_MAX)
                    r_replay_cnt <= r_replay_cnt + CNT_ONE;
            end
            // Flag rises on the same edge StallCnt reaches the limit
            if (w_state_nxt == HOLD && w_stall_cnt_nxt == TIMEOUT_VAL)
                r_timeout <= 1'b1;
        end
    end

    assign bus.MemReqValidQ103H  = w_mem_valid;
    assign bus.MemReqAddrQ103H   = w_mem_req.addr;
    assign bus.MemReqDataQ103H   = w_mem_req.data;
    assign bus.MemReqByteEnQ103H = w_mem_req.be;
    assign bus.MemReqWrEnQ103H   = w_mem_req.wr;
    assign bus.MemReqRdEnQ103H   = w_mem_req.rd;
    assign bus.CoreStall         = w_stall;
    assign bus.ReplayQ103H       = w_replay;
    assign bus.StallCnt          = r_stall_cnt;
    assign bus.ReplayCnt         = r_replay_cnt;
    assign bus.TimeoutErr        = r_timeout;
endmodule

// File: tb/tb_d_mem_req_hold.sv
// Directed bench for d_mem_req_hold: pass-through, hold/replay, back-to-back,
// watchdog, reset during hold and idle-with-not-ready.
module tb_d_mem_req_hold;
    logic clk = 1'b0;
    logic rst_n = 1'b0;
    int   n_vec = 0;
    int   n_err = 0;
    int   issue_cnt = 0;
    int   snap;

    d_mem_req_hold_if #(.CNT_W(16)) bus ();

    d_mem_req_hold #(.TIMEOUT_CYCLES(8), .CNT_W(16)) dut (
        .i_clk   (clk),
        .i_rst_n (rst_n),
        .bus     (bus)
    );

    always #5 clk = ~clk;

    // Counts requests actually accepted by memory
    always @(posedge clk)
        if (rst_n && bus.MemReqValidQ103H && bus.DMemReady) issue_cnt++;

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "time limit");
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic v, input logic [31:0] a, input logic [31:0] d,
                         input logic [3:0] be, input logic wr, input logic rd);
        bus.CoreReqValidQ103H  = v;
        bus.CoreReqAddrQ103H   = a;
        bus.CoreReqDataQ103H   = d;
        bus.CoreReqByteEnQ103H = be;
        bus.CoreReqWrEnQ103H   = wr;
        bus.CoreReqRdEnQ103H   = rd;
    endtask

    initial begin
        bus.DMemReady = 1'b0;
        drive(1'b0, 32'h0, 32'h0, 4'h0, 1'b0, 1'b0);
        tick();
        tick();
        // reset state
        chk("rst_valid",   {31'd0, bus.MemReqValidQ103H}, 32'd0);
        chk("rst_stall",   {31'd0, bus.CoreStall},        32'd0);
        chk("rst_replay",  {31'd0, bus.ReplayQ103H},      32'd0);
        chk("rst_stallcnt", {16'd0, bus.StallCnt},        32'd0);
        chk("rst_replaycnt", {16'd0, bus.ReplayCnt},      32'd0);
        chk("rst_timeout", {31'd0, bus.TimeoutErr},       32'd0);
        rst_n = 1'b1;
        tick();

        // 1: ready pass-through read
        bus.DMemReady = 1'b1;
        drive(1'b1, 32'h0000_1000, 32'h0, 4'hF, 1'b0, 1'b1);
        #1;
        chk("t1_valid", {31'd0, bus.MemReqValidQ103H}, 32'd1);
        chk("t1_addr",  bus.MemReqAddrQ103H,           32'h0000_1000);
        chk("t1_rd",    {31'd0, bus.MemReqRdEnQ103H},  32'd1);
        chk("t1_wr",    {31'd0, bus.MemReqWrEnQ103H},  32'd0);
        chk("t1_stall", {31'd0, bus.CoreStall},        32'd0);
        chk("t1_replay", {31'd0, bus.ReplayQ103H},     32'd0);
        tick();
        chk("t1_replaycnt", {16'd0, bus.ReplayCnt},    32'd0);

        // 2: write held for 3 not-ready cycles, inputs change meanwhile
        bus.DMemReady = 1'b0;
        drive(1'b1, 32'h0000_2004, 32'hDEAD_BEEF, 4'hF, 1'b1, 1'b0);
        #1;
        chk("t2_c1_stall", {31'd0, bus.CoreStall},   32'd1);
        chk("t2_c1_addr",  bus.MemReqAddrQ103H,      32'h0000_2004);
        chk("t2_c1_replay", {31'd0, bus.ReplayQ103H}, 32'd0);
        tick();
        drive(1'b1, 32'h0000_5555, 32'h0000_1234, 4'h3, 1'b0, 1'b1);
        #1;
        chk("t2_c2_stall", {31'd0, bus.CoreStall},   32'd1);
        chk("t2_c2_replay", {31'd0, bus.ReplayQ103H}, 32'd1);
        chk("t2_c2_addr",  bus.MemReqAddrQ103H,      32'h0000_2004);
        chk("t2_c2_data",  bus.MemReqDataQ103H,      32'hDEAD_BEEF);
        chk("t2_c2_be",    {28'd0, bus.MemReqByteEnQ103H}, 32'hF);
        chk("t2_c2_wr",    {31'd0, bus.MemReqWrEnQ103H}, 32'd1);
        chk("t2_c2_rd",    {31'd0, bus.MemReqRdEnQ103H}, 32'd0);
        chk("t2_c2_stallcnt", {16'd0, bus.StallCnt}, 32'd1);
        chk("t2_c2_replaycnt", {16'd0, bus.ReplayCnt}, 32'd1);
        tick();
        chk("t2_c3_stall", {31'd0, bus.CoreStall},   32'd1);
        chk("t2_c3_data",  bus.MemReqDataQ103H,      32'hDEAD_BEEF);
        chk("t2_c3_stallcnt", {16'd0, bus.StallCnt}, 32'd2);
        tick();
        bus.DMemReady = 1'b1;
        snap = issue_cnt;
        #1;
        chk("t2_c4_stall", {31'd0, bus.CoreStall},   32'd0);
        chk("t2_c4_replay", {31'd0, bus.ReplayQ103H}, 32'd1);
        chk("t2_c4_addr",  bus.MemReqAddrQ103H,      32'h0000_2004);
        chk("t2_c4_stallcnt", {16'd0, bus.StallCnt}, 32'd3);
        tick();
        chk("t2_issue",    issue_cnt - snap,         32'd1);
        chk("t2_c5_replay", {31'd0, bus.ReplayQ103H}, 32'd0);
        chk("t2_c5_addr",  bus.MemReqAddrQ103H,      32'h0000_5555);
        chk("t2_c5_stallcnt", {16'd0, bus.StallCnt}, 32'd0);
        chk("t2_c5_replaycnt", {16'd0, bus.ReplayCnt}, 32'd1);
        tick();

        // 3: back-to-back holds, one not-ready cycle each
        snap = issue_cnt;
        bus.DMemReady = 1'b0;
        drive(1'b1, 32'h0000_0100, 32'h0000_00AA, 4'h1, 1'b1, 1'b0);
        #1;
        chk("t3_a_stall", {31'd0, bus.CoreStall}, 32'd1);
        tick();
        bus.DMemReady = 1'b1;
        drive(1'b1, 32'h0000_0200, 32'h0000_00BB, 4'h2, 1'b0, 1'b1);
        #1;
        chk("t3_a_addr",  bus.MemReqAddrQ103H,      32'h0000_0100);
        chk("t3_a_replay", {31'd0, bus.ReplayQ103H}, 32'd1);
        chk("t3_a_stall2", {31'd0, bus.CoreStall},  32'd0);
        tick();
        bus.DMemReady = 1'b0;
        #1;
        chk("t3_b_addr",  bus.MemReqAddrQ103H,      32'h0000_0200);
        chk("t3_b_stall", {31'd0, bus.CoreStall},   32'd1);
        chk("t3_b_replay", {31'd0, bus.ReplayQ103H}, 32'd0);
        chk("t3_b_stallcnt", {16'd0, bus.StallCnt}, 32'd0);
        chk("t3_b_replaycnt", {16'd0, bus.ReplayCnt}, 32'd2);
        tick();
        bus.DMemReady = 1'b1;
        drive(1'b0, 32'h0, 32'h0, 4'h0, 1'b0, 1'b0);
        #1;
        chk("t3_b_held_addr", bus.MemReqAddrQ103H,   32'h0000_0200);
        chk("t3_b_held_replay", {31'd0, bus.ReplayQ103H}, 32'd1);
        chk("t3_b_replaycnt2", {16'd0, bus.ReplayCnt}, 32'd3);
        tick();
        chk("t3_end_valid", {31'd0, bus.MemReqValidQ103H}, 32'd0);
        chk("t3_end_stallcnt", {16'd0, bus.StallCnt}, 32'd0);
        tick();
        chk("t3_issue", issue_cnt - snap, 32'd2);

        // 4: watchdog with limit 8, ten not-ready cycles
        bus.DMemReady = 1'b0;
        drive(1'b1, 32'h0000_0300, 32'h0000_0033, 4'hF, 1'b1, 1'b0);
        for (int k = 1; k <= 9; k++) begin
            tick();
            chk("t4_stallcnt", {16'd0, bus.StallCnt}, k);
            chk("t4_timeout", {31'd0, bus.TimeoutErr}, (k >= 8) ? 32'd1 : 32'd0);
        end
        tick();
        bus.DMemReady = 1'b1;
        snap = issue_cnt;
        #1;
        chk("t4_last_stallcnt", {16'd0, bus.StallCnt}, 32'd10);
        chk("t4_last_stall", {31'd0, bus.CoreStall},   32'd0);
        chk("t4_last_addr",  bus.MemReqAddrQ103H,      32'h0000_0300);
        tick();
        drive(1'b0, 32'h0, 32'h0, 4'h0, 1'b0, 1'b0);
        #1;
        chk("t4_issue", issue_cnt - snap, 32'd1);
        chk("t4_sticky", {31'd0, bus.TimeoutErr}, 32'd1);
        chk("t4_stallcnt0", {16'd0, bus.StallCnt}, 32'd0);
        chk("t4_replaycnt", {16'd0, bus.ReplayCnt}, 32'd4);
        tick();

        // 5: reset while holding discards the request
        bus.DMemReady = 1'b0;
        drive(1'b1, 32'h0000_0400, 32'h0000_0044, 4'hF, 1'b0, 1'b1);
        tick();
        chk("t5_hold_replay", {31'd0, bus.ReplayQ103H}, 32'd1);
        rst_n = 1'b0;
        drive(1'b0, 32'h0, 32'h0, 4'h0, 1'b0, 1'b0);
        snap = issue_cnt;
        tick();
        rst_n = 1'b1;
        #1;
        chk("t5_valid",   {31'd0, bus.MemReqValidQ103H}, 32'd0);
        chk("t5_replay",  {31'd0, bus.ReplayQ103H},      32'd0);
        chk("t5_stallcnt", {16'd0, bus.StallCnt},        32'd0);
        chk("t5_replaycnt", {16'd0, bus.ReplayCnt},      32'd0);
        chk("t5_timeout", {31'd0, bus.TimeoutErr},       32'd0);
        bus.DMemReady = 1'b1;
        tick();
        tick();
        chk("t5_issue", issue_cnt - snap, 32'd0);

        // 6: no request while not ready
        bus.DMemReady = 1'b0;
        #1;
        chk("t6_stall", {31'd0, bus.CoreStall},        32'd0);
        chk("t6_valid", {31'd0, bus.MemReqValidQ103H}, 32'd0);
        tick();
        chk("t6_replay", {31'd0, bus.ReplayQ103H},     32'd0);
        chk("t6_stallcnt", {16'd0, bus.StallCnt},      32'd0);
        chk("t6_replaycnt", {16'd0, bus.ReplayCnt},    32'd0);

        // Valid with neither read nor write is held like any request
        drive(1'b1, 32'h0000_0600, 32'h0000_0066, 4'h8, 1'b0, 1'b0);
        tick();
        chk("t7_replay", {31'd0, bus.ReplayQ103H},     32'd1);
        chk("t7_valid",  {31'd0, bus.MemReqValidQ103H}, 32'd1);
        chk("t7_addr",   bus.MemReqAddrQ103H,          32'h0000_0600);
        chk("t7_be",     {28'd0, bus.MemReqByteEnQ103H}, 32'h8);
        bus.DMemReady = 1'b1;
        tick();
        drive(1'b0, 32'h0, 32'h0, 4'h0, 1'b0, 1'b0);
        #1;
        chk("t7_replaycnt", {16'd0, bus.ReplayCnt}, 32'd1);
        chk("t7_idle_replay", {31'd0, bus.ReplayQ103H}, 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
